stage_execute: RTL and testbench

Execute stage of the pipelined RV32 core. Sits between the ID/EX register and the MEM/WB register: selects forwarded operands, computes ALU results, and resolves branches and jumps. An iterative 32-cycle divider handles DIV/DIVU/REM/REMU and stalls the front of the pipe. The block registers everything the memory stage consumes as `mem_*` signals.

---
 rtl/stage_execute.sv | 215 +++++++++++++++++++++
 tb/tb_stage_execute.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_execute.sv
// RV32 execute stage: operand forwarding, ALU, branch/jump resolution,
// a 32-iteration restoring divider that stalls the front of the pipe, and the EX/MEM register.
module stage_execute #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_clear,
  input  logic        ex_reg_write,
  input  logic        ex_mem_write,
  input  logic        ex_jump,
  input  logic        ex_jalr,
  input  logic        ex_branch,
  input  logic        ex_alu_src,
  input  logic [1:0]  ex_result_src,
  input  logic [2:0]  ex_funct3,
  input  logic [3:0]  ex_alu_control,
  input  logic [31:0] ex_rd1,
  input  logic [31:0] ex_rd2,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_pc_plus_4,
  input  logic [31:0] ex_imm_ext,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic [31:0] wb_result,
  output logic        ex_busy,
  output logic        ex_pc_src,
  output logic [31:0] ex_pc_target,
  output logic        mem_reg_write,
  output logic        mem_mem_write,
  output logic [1:0]  mem_result_src,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_pc_plus_4,
  output logic [31:0] mem_imm_ext,
  output logic [4:0]  mem_rd
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU = 4'd6,  OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,  OP_SRA  = 4'd9,  OP_DIV  = 4'd10, OP_DIVU = 4'd11,
    OP_REM  = 4'd12, OP_REMU = 4'd13
  } alu_op_t;

  localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 1);

  alu_op_t     op;
  logic [31:0] src_a, fwd_b, src_b;
  logic [31:0] alu_result;
  logic [31:0] div_result;
  logic        is_div;
  logic        cond;

  div_state_t  state_q, state_d;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [5:0]  count_q;
  logic        neg_q_q, neg_r_q, div_zero_q, want_rem_q;

  assign op     = alu_op_t'(ex_alu_control);
  assign is_div = (ex_alu_control >= 4'd10) && (ex_alu_control <= 4'd13);

  always_comb begin
    case (forward_a)
      2'b01:   src_a = wb_result;
      2'b10:   src_a = mem_alu_result;
      default: src_a = ex_rd1;
    endcase
    case (forward_b)
      2'b01:   fwd_b = wb_result;
      2'b10:   fwd_b = mem_alu_result;
      default: fwd_b = ex_rd2;
    endcase
    src_b = ex_alu_src ? ex_imm_ext : fwd_b;
  end

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = src_a - src_b;
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_SLT:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_result = {31'b0, src_a < src_b};
      OP_SLL:  alu_result = src_a << src_b[4:0];
      OP_SRL:  alu_result = src_a >> src_b[4:0];
      OP_SRA:  alu_result = $signed(src_a) >>> src_b[4:0];
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_result = div_result;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = (src_a == fwd_b);
      3'b001:  cond = (src_a != fwd_b);
      3'b100:  cond = ($signed(src_a) < $signed(fwd_b));
      3'b101:  cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  cond = (src_a < fwd_b);
      3'b111:  cond = (src_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign ex_pc_target = ex_jalr ? ((src_a + ex_imm_ext) & ~32'd1) : (ex_pc + ex_imm_ext);
  assign ex_pc_src    = (ex_jump | (ex_branch & cond)) & ~ex_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ex_busy = 1'b0;
    case (state_q)
      IDLE: begin
        ex_busy = is_div;
        if (is_div) state_d = RUN;
      end
      RUN: begin
        ex_busy = 1'b1;
        if (count_q == LAST_ITER) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mem_clear) state_d = IDLE;
  end

  // Divider works on magnitudes; signs are reapplied when the result is read out in DONE.
  logic        signed_op, a_neg, b_neg;
  logic [32:0] rem_shift, rem_diff;

  assign signed_op = (op == OP_DIV) || (op == OP_REM);
  assign a_neg     = signed_op & src_a[31];
  assign b_neg     = signed_op & src_b[31];
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      count_q    <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      want_rem_q <= 1'b0;
    end else if (mem_clear) begin
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (is_div) begin
          quo_q      <= a_neg ? -src_a : src_a;
          dvs_q      <= b_neg ? -src_b : src_b;
          rem_q      <= '0;
          count_q    <= '0;
          neg_q_q    <= a_neg ^ b_neg;
          neg_r_q    <= a_neg;
          div_zero_q <= (src_b == '0);
          want_rem_q <= (op == OP_REM) || (op == OP_REMU);
        end
        RUN: begin
          if (!rem_diff[32]) begin
            rem_q <= rem_diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= rem_shift[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
          count_q <= count_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // A zero divisor leaves the dividend magnitude in rem_q, so only the quotient needs overriding.
  always_comb begin
    if (want_rem_q)      div_result = neg_r_q ? -rem_q : rem_q;
    else if (div_zero_q) div_result = '1;
    else                 div_result = neg_q_q ? -quo_q : quo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || mem_clear || ex_busy) begin
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_result_src <= '0;
      mem_alu_result <= '0;
      mem_write_data <= '0;
      mem_pc_plus_4  <= '0;
      mem_imm_ext    <= '0;
      mem_rd         <= '0;
    end else begin
      mem_reg_write  <= ex_reg_write;
      mem_mem_write  <= ex_mem_write;
      mem_result_src <= ex_result_src;
      mem_alu_result <= alu_result;
      mem_write_data <= fwd_b;
      mem_pc_plus_4  <= ex_pc_plus_4;
      mem_imm_ext    <= ex_imm_ext;
      mem_rd         <= ex_rd;
    end
  end

endmodule

// File: tb/tb_stage_execute.sv
// Directed-vector bench for stage_execute: ALU table, branches, JALR, divider latency and flush/reset behaviour.
module tb_stage_execute;

  logic        clk = 1'b0;
  logic        rst, mem_clear;
  logic        ex_reg_write, ex_mem_write, ex_jump, ex_jalr, ex_branch, ex_alu_src;
  logic [1:0]  ex_result_src;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_rd1, ex_rd2, ex_pc, ex_pc_plus_4, ex_imm_ext;
  logic [4:0]  ex_rd;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] wb_result;
  logic        ex_busy, ex_pc_src;
  logic [31:0] ex_pc_target;
  logic        mem_reg_write, mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext;
  logic [4:0]  mem_rd;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  stage_execute #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .mem_clear(mem_clear),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_jump(ex_jump),
    .ex_jalr(ex_jalr), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
    .ex_result_src(ex_result_src), .ex_funct3(ex_funct3), .ex_alu_control(ex_alu_control),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_pc(ex_pc), .ex_pc_plus_4(ex_pc_plus_4),
    .ex_imm_ext(ex_imm_ext), .ex_rd(ex_rd), .forward_a(forward_a), .forward_b(forward_b),
    .wb_result(wb_result), .ex_busy(ex_busy), .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_pc_plus_4(mem_pc_plus_4), .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_reg_write = 0; ex_mem_write = 0; ex_jump = 0; ex_jalr = 0; ex_branch = 0;
    ex_alu_src = 0; ex_result_src = 0; ex_funct3 = 0; ex_alu_control = 0;
    ex_rd1 = 0; ex_rd2 = 0; ex_pc = 0; ex_pc_plus_4 = 0; ex_imm_ext = 0; ex_rd = 0;
    forward_a = 0; forward_b = 0; wb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    ex_alu_control = op; ex_rd1 = a; ex_rd2 = b;
    ex_reg_write = 1; ex_rd = 5'd5; ex_pc_plus_4 = 32'h44;
  endtask

  // Operands are disturbed after the first edge; the result must still reflect the IDLE-cycle values.
  task automatic run_div(input string tag, input logic [31:0] exp);
    int unsigned busy_n = 0;
    int unsigned bubbles = 0;
    #1;
    check({tag, "_busy_at_start"}, {31'b0, ex_busy}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (!ex_busy) break;
      busy_n++;
      step();
      if (i == 0) begin
        ex_rd1 = ~ex_rd1; ex_rd2 = ex_rd2 + 32'h3; wb_result = ~wb_result;
      end
      if (mem_alu_result == 0 && mem_reg_write == 0 && mem_rd == 0 && mem_pc_plus_4 == 0)
        bubbles++;
    end
    check({tag, "_busy_cycles"}, busy_n, 32'd33);
    check({tag, "_bubbles"}, bubbles, 32'd33);
    step();
    check({tag, "_result"}, mem_alu_result, exp);
    check({tag, "_rd"}, {27'b0, mem_rd}, 32'd5);
    check({tag, "_pc4"}, mem_pc_plus_4, 32'h44);
  endtask

  logic [3:0]  alu_op  [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd14, 4'd7};
  logic [31:0] alu_a   [12] = '{32'hFFFFFFFF, 32'd3, 32'hF0F0, 32'hF0F0, 32'hFF, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h80000000, 32'd5, 32'd1};
  logic [31:0] alu_b   [12] = '{32'd1, 32'd5, 32'hFF00, 32'h0F0F, 32'h0F, 32'd1,
                                32'd1, 32'd31, 32'd4, 32'd4, 32'd5, 32'h21};
  logic [31:0] alu_exp [12] = '{32'h0, 32'hFFFFFFFE, 32'hF000, 32'hFFFF, 32'hF0, 32'd1,
                                32'd0, 32'h80000000, 32'h08000000, 32'hF8000000, 32'd0, 32'd2};

  logic [2:0]  br_f3  [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
  logic        br_exp [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [3:0]  dv_op  [7] = '{4'd10, 4'd12, 4'd11, 4'd13, 4'd10, 4'd12, 4'd11};
  logic [31:0] dv_a   [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h1234, 32'h1234,
                              32'h80000000, 32'h80000000, 32'd100};
  logic [31:0] dv_b   [7] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
  logic [31:0] dv_exp [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234,
                              32'h80000000, 32'h0, 32'd14};

  initial begin
    idle_inputs();
    rst = 1; mem_clear = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, ex_busy}, 32'd0);
    check("rst_alu", mem_alu_result, 32'd0);
    check("rst_regw", {31'b0, mem_reg_write}, 32'd0);

    @(negedge clk);
    rst = 0;
    ex_rd1 = 2; ex_rd2 = 3; ex_reg_write = 1; ex_rd = 5'd3;
    step();
    check("add", mem_alu_result, 32'd5);
    check("add_rd", {27'b0, mem_rd}, 32'd3);
    check("add_wdata", mem_write_data, 32'd3);

    ex_rd1 = 99; forward_a = 2'b10; ex_rd2 = 7;
    step();
    check("fwd_mem_add", mem_alu_result, 32'd12);

    forward_a = 2'b00; forward_b = 2'b01; wb_result = 32'h55; ex_rd1 = 32'h10;
    ex_alu_src = 1; ex_imm_ext = 4; ex_alu_control = 4'd4; ex_mem_write = 1;
    step();
    check("fwd_wb_xor_imm", mem_alu_result, 32'h14);
    check("fwd_wb_wdata", mem_write_data, 32'h55);
    check("mem_write", {31'b0, mem_mem_write}, 32'd1);
    check("imm_pass", mem_imm_ext, 32'd4);

    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      ex_alu_control = alu_op[i]; ex_rd1 = alu_a[i]; ex_rd2 = alu_b[i];
      step();
      check($sformatf("alu_%0d", i), mem_alu_result, alu_exp[i]);
    end

    @(negedge clk);
    idle_inputs();
    ex_branch = 1; ex_rd1 = 32'hFFFFFFFF; ex_rd2 = 32'd1; ex_pc = 32'h100; ex_imm_ext = 32'h20;
    for (int i = 0; i < 7; i++) begin
      ex_funct3 = br_f3[i];
      #1;
      check($sformatf("br_f3_%0d", br_f3[i]), {31'b0, ex_pc_src}, {31'b0, br_exp[i]});
    end
    check("br_target", ex_pc_target, 32'h120);

    @(negedge clk);
    idle_inputs();
    ex_jump = 1; ex_jalr = 1; ex_rd1 = 32'h1003; ex_imm_ext = 32'h4; ex_alu_src = 1;
    ex_pc = 32'h500; ex_pc_plus_4 = 32'h2004; ex_result_src = 2'd2; ex_reg_write = 1; ex_rd = 5'd1;
    #1;
    check("jalr_src", {31'b0, ex_pc_src}, 32'd1);
    check("jalr_target", ex_pc_target, 32'h1006);
    step();
    check("jalr_pc4", mem_pc_plus_4, 32'h2004);
    check("jalr_rsrc", {30'b0, mem_result_src}, 32'd2);
    check("jalr_rd", {27'b0, mem_rd}, 32'd1);

    @(negedge clk);
    rst = 1;
    idle_inputs();
    #1;
    check("async_rst_pc4", mem_pc_plus_4, 32'd0);
    check("async_rst_rsrc", {30'b0, mem_result_src}, 32'd0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      set_div(dv_op[i], dv_a[i], dv_b[i]);
      run_div($sformatf("div_%0d", i), dv_exp[i]);
    end

    @(negedge clk);
    set_div(4'd11, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    mem_clear = 1;
    idle_inputs();
    ex_rd1 = 1; ex_rd2 = 1; ex_reg_write = 1;
    #1;
    check("clr_run_busy_before", {31'b0, ex_busy}, 32'd1);
    step();
    check("clr_run_busy_after", {31'b0, ex_busy}, 32'd0);
    check("clr_run_bubble", {31'b0, mem_reg_write}, 32'd0);
    mem_clear = 0;
    step();
    check("clr_run_then_add", mem_alu_result, 32'd2);

    @(negedge clk);
    mem_clear = 1;
    set_div(4'd10, 32'hFFFFFFF9, 32'd2);
    #1;
    check("clr_idle_busy", {31'b0, ex_busy}, 32'd1);
    step();
    check("clr_idle_bubble", {31'b0, mem_reg_write}, 32'd0);
    mem_clear = 0;
    run_div("clr_idle_div", 32'hFFFFFFFD);

    @(negedge clk);
    set_div(4'd10, 32'd50, 32'd3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1;
    idle_inputs();
    ex_rd1 = 2; ex_rd2 = 2;
    #1;
    check("rst_run_busy", {31'b0, ex_busy}, 32'd0);
    check("rst_run_alu", mem_alu_result, 32'd0);
    @(negedge clk);
    rst = 0; ex_reg_write = 1;
    step();
    check("rst_run_then_add", mem_alu_result, 32'd4);
    check("rst_run_then_regw", {31'b0, mem_reg_write}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
